// File: rtl/cond_flag_unit.sv
// cond_flag_unit: holds the committed NZCV flag register and evaluates each
// instruction's condition field against it. Failed conditions gate off the
// side-effect controls. The result sits in a one-entry valid/ready stage
// toward writeback, and saturating executed/skipped counters support debug.
module cond_flag_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       cond,
   input  logic [1:0]       flag_w,
   input  logic [3:0]       alu_flags,
   input  logic             reg_write,
   input  logic             mem_write,
   input  logic             pc_src,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             reg_write_q,
   output logic             mem_write_q,
   output logic             pc_src_q,
   output logic             cond_ex_q,
   output logic             undef_q,
   output logic [3:0]       nzcv,
   output logic [CNT_W-1:0] exec_cnt,
   output logic [CNT_W-1:0] skip_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic accept;
   logic cond_ex;
   logic n_f, z_f, c_f, v_f;

   assign {n_f, z_f, c_f, v_f} = nzcv;

   // The stage frees up when empty or when its word is draining this cycle.
   assign in_ready = ~out_valid | out_ready;
   assign accept   = in_valid & in_ready;

   // Condition evaluation uses the committed flags only; this instruction's own
   // alu_flags never bypass into its own condition.
   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         4'h0: cond_ex = z_f;
         4'h1: cond_ex = ~z_f;
         4'h2: cond_ex = c_f;
         4'h3: cond_ex = ~c_f;
         4'h4: cond_ex = n_f;
         4'h5: cond_ex = ~n_f;
         4'h6: cond_ex = v_f;
         4'h7: cond_ex = ~v_f;
         4'h8: cond_ex = c_f & ~z_f;
         4'h9: cond_ex = ~c_f | z_f;
         4'hA: cond_ex = (n_f == v_f);
         4'hB: cond_ex = (n_f != v_f);
         4'hC: cond_ex = ~z_f & (n_f == v_f);
         4'hD: cond_ex = z_f | (n_f != v_f);
         4'hE: cond_ex = 1'b1;
         4'hF: cond_ex = 1'b0;
         default: cond_ex = 1'b0;
      endcase
   end

   // Output stage: load on accept, empty on drain, hold everything on stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         reg_write_q <= 1'b0;
         mem_write_q <= 1'b0;
         pc_src_q    <= 1'b0;
         cond_ex_q   <= 1'b0;
         undef_q     <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         reg_write_q <= reg_write & cond_ex;
         mem_write_q <= mem_write & cond_ex;
         pc_src_q    <= pc_src & cond_ex;
         cond_ex_q   <= cond_ex;
         undef_q     <= (cond == 4'hF);
      end else if (out_ready) begin
         out_valid   <= 1'b0;
      end
   end

   // Flag register: only instructions that pass their condition may write it,
   // with N/Z and C/V enabled independently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nzcv <= 4'h0;
      end else if (accept && cond_ex) begin
         if (flag_w[1]) nzcv[3:2] <= alu_flags[3:2];
         if (flag_w[0]) nzcv[1:0] <= alu_flags[1:0];
      end
   end

   // Debug counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exec_cnt <= '0;
         skip_cnt <= '0;
      end else if (accept) begin
         if (cond_ex) begin
            if (exec_cnt != CNT_MAX) exec_cnt <= exec_cnt + CNT_W'(1);
         end else begin
            if (skip_cnt != CNT_MAX) skip_cnt <= skip_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit with hand-computed expected values.
// Counters are 4 bits wide so saturation is reachable quickly.
module tb_cond_flag_unit;

   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       cond;
   logic [1:0]       flag_w;
   logic [3:0]       alu_flags;
   logic             reg_write;
   logic             mem_write;
   logic             pc_src;
   logic             out_valid;
   logic             out_ready;
   logic             reg_write_q;
   logic             mem_write_q;
   logic             pc_src_q;
   logic             cond_ex_q;
   logic             undef_q;
   logic [3:0]       nzcv;
   logic [CNT_W-1:0] exec_cnt;
   logic [CNT_W-1:0] skip_cnt;

   int checks   = 0;
   int failures = 0;

   cond_flag_unit #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .cond       (cond),
      .flag_w     (flag_w),
      .alu_flags  (alu_flags),
      .reg_write  (reg_write),
      .mem_write  (mem_write),
      .pc_src     (pc_src),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .reg_write_q(reg_write_q),
      .mem_write_q(mem_write_q),
      .pc_src_q   (pc_src_q),
      .cond_ex_q  (cond_ex_q),
      .undef_q    (undef_q),
      .nzcv       (nzcv),
      .exec_cnt   (exec_cnt),
      .skip_cnt   (skip_cnt)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one instruction for one edge, then sample 1 ns after that edge.
   task automatic send(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                       input logic rw, input logic mw, input logic ps);
      cond      = c;
      flag_w    = fw;
      alu_flags = af;
      reg_write = rw;
      mem_write = mw;
      pc_src    = ps;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #2;
      rst_n    = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cond      = 4'h0;
      flag_w    = 2'b00;
      alu_flags = 4'h0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      pc_src    = 1'b0;
      #12;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset mid-cycle clears a live result immediately
      send(4'hE, 2'b11, 4'hF, 1'b1, 1'b1, 1'b1);
      check("pre_rst_nzcv", 32'(nzcv), 32'hF);
      check("pre_rst_valid", 32'(out_valid), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_q", 32'({reg_write_q, mem_write_q, pc_src_q, cond_ex_q, undef_q}), 32'h0);
      check("rst_nzcv", 32'(nzcv), 32'h0);
      check("rst_cnts", 32'({exec_cnt, skip_cnt}), 32'h0);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'h1);

      // Flag update then use
      send(4'hE, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0);
      check("t2_nzcv", 32'(nzcv), 32'h4);
      send(4'h0, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0);
      check("t2_eq_rw", 32'(reg_write_q), 32'h1);
      check("t2_eq_ex", 32'(cond_ex_q), 32'h1);
      send(4'h1, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0);
      check("t2_ne_rw", 32'(reg_write_q), 32'h0);
      check("t2_skip", 32'(skip_cnt), 32'h1);
      check("t2_exec", 32'(exec_cnt), 32'h2);

      // Partial write: only C,V updated
      do_reset();
      send(4'hE, 2'b01, 4'hF, 1'b0, 1'b0, 1'b0);
      check("t3_nzcv", 32'(nzcv), 32'h3);
      send(4'hA, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0);
      check("t3_ge_ex", 32'(cond_ex_q), 32'h0);
      check("t3_ge_rw", 32'(reg_write_q), 32'h0);
      send(4'hB, 2'b00, 4'h0, 1'b0, 1'b1, 1'b1);
      check("t3_lt_mw_pc", 32'({mem_write_q, pc_src_q}), 32'h3);
      send(4'h8, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
      check("t3_hi_ex", 32'(cond_ex_q), 32'h1);
      check("t3_undef", 32'(undef_q), 32'h0);

      // A failed condition must not write flags
      do_reset();
      send(4'h0, 2'b11, 4'b1000, 1'b0, 1'b0, 1'b0);
      check("t4_nzcv", 32'(nzcv), 32'h0);
      check("t4_ex", 32'(cond_ex_q), 32'h0);
      check("t4_skip", 32'(skip_cnt), 32'h1);

      // Backpressure: hold for 3 cycles, then drain and accept together
      do_reset();
      send(4'hE, 2'b11, 4'b0010, 1'b0, 1'b0, 1'b0);
      check("t5_nzcv0", 32'(nzcv), 32'h2);
      out_ready = 1'b0;
      cond      = 4'hE;
      flag_w    = 2'b11;
      alu_flags = 4'b1000;
      reg_write = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("t5_in_ready", 32'(in_ready), 32'h0);
         check("t5_hold", 32'({out_valid, reg_write_q, nzcv, exec_cnt}), 32'({1'b1, 1'b0, 4'h2, 4'h1}));
      end
      out_ready = 1'b1;
      #1;
      check("t5_ready_comb", 32'(in_ready), 32'h1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("t5_swap", 32'({out_valid, reg_write_q, nzcv, exec_cnt}), 32'({1'b1, 1'b1, 4'h8, 4'h2}));
      @(posedge clk);
      #1;
      check("t5_drain", 32'(out_valid), 32'h0);

      // Reset during a stall drops the pending word
      send(4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_stall", 32'({out_valid, nzcv, exec_cnt}), 32'h0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Counter saturation and reserved condition
      do_reset();
      for (int i = 0; i < 20; i++) send(4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
      check("t6_exec_sat", 32'(exec_cnt), 32'hF);
      send(4'hF, 2'b11, 4'hF, 1'b1, 1'b0, 1'b0);
      check("t6_undef", 32'(undef_q), 32'h1);
      check("t6_skip", 32'(skip_cnt), 32'h1);
      check("t6_rw", 32'({reg_write_q, cond_ex_q}), 32'h0);
      check("t6_nzcv", 32'(nzcv), 32'h0);
      check("t6_exec_hold", 32'(exec_cnt), 32'hF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
